// File: rtl/imm_encoder_if.sv
// Field-bundle handshake and instruction-memory write port of the immediate encoder.
// The encoder is the slave; the loader/sequencer (or bench) is the master.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ImmSrc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output in_valid, ImmSrc, opcode, funct3, rd, rs1, rs2, imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, ImmSrc, opcode, funct3, rd, rs1, rs2, imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imm_encoder.sv
// Immediate encoder: range-checks a signed immediate, packs an I/S/B(/J) word and writes it
// to instruction memory at an auto-incrementing address. J-type is enabled by IMM_J_TYPE_EN.
module imm_encoder #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    imm_encoder_if.slave               bus,
    output logic                       busy,
    output logic                       full,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFull, StErr} state_e;

    state_e            state_q, state_d;
    logic              in_ready;
    logic              accept;
    logic              legal;
    logic [1:0]        chk_code;
    logic [31:0]       enc_word;
    logic [31:0]       ptr_q;
    logic [CntW-1:0]   count_q;
    logic              err_q;
    logic [1:0]        err_code_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              fits_12;
    logic              fits_13;
    logic [31:0]       imm;

    assign imm = bus.imm;

    // An immediate fits N bits when everything above bit N-1 is pure sign extension.
    assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
`ifdef IMM_J_TYPE_EN
    logic fits_21;
    assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);
`endif

    always_comb begin
        chk_code = 2'b00;
        enc_word = '0;
        unique case (bus.ImmSrc)
            2'b00: begin
                enc_word = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                if (!fits_12) chk_code = 2'b01;
            end
            2'b01: begin
                enc_word = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode};
                if (!fits_12) chk_code = 2'b01;
            end
            2'b10: begin
                enc_word = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3, imm[4:1], imm[11],
                            bus.opcode};
                if (imm[0])        chk_code = 2'b10;
                else if (!fits_13) chk_code = 2'b01;
            end
            2'b11: begin
`ifdef IMM_J_TYPE_EN
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
                if (imm[0])        chk_code = 2'b10;
                else if (!fits_21) chk_code = 2'b01;
`else
                chk_code = 2'b11;
`endif
            end
        endcase
    end

    assign legal  = (chk_code == 2'b00);
    assign accept = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = StRun;
        end else if (accept) begin
            if (!legal)                               state_d = StErr;
            else if (count_q == CntW'(DEPTH - 1))     state_d = StFull;
        end
    end

    always_comb begin
        in_ready = (state_q == StRun) && !start;
        busy     = (state_q == StRun);
        full     = (state_q == StFull);
    end

    // A write pending from the previous cycle still drains while start is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= BASE_ADDR;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            we_q <= 1'b0;
            if (start) begin
                ptr_q      <= BASE_ADDR;
                count_q    <= '0;
                err_q      <= 1'b0;
                err_code_q <= 2'b00;
            end else if (accept) begin
                if (legal) begin
                    we_q    <= 1'b1;
                    addr_q  <= ptr_q;
                    wdata_q <= enc_word;
                    ptr_q   <= ptr_q + 32'd4;
                    count_q <= count_q + 1'b1;
                end else begin
                    err_q      <= 1'b1;
                    err_code_q <= chk_code;
                end
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign err            = err_q;
    assign err_code       = err_code_q;
    assign count          = count_q;
endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder (DEPTH=4): encodings, errors, full, restart, async reset.
module tb_imm_encoder;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       full;
    logic       err;
    logic [1:0] err_code;
    logic [2:0] count;
    int         total;
    int         bad;

    imm_encoder_if bus ();

    imm_encoder #(
        .DEPTH    (4),
        .BASE_ADDR(32'h0000_0000)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bus     (bus),
        .busy    (busy),
        .full    (full),
        .err     (err),
        .err_code(err_code),
        .count   (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [1:0] src, input logic [6:0] op, input logic [2:0] f3,
                           input logic [4:0] rd_v, input logic [4:0] rs1_v,
                           input logic [4:0] rs2_v, input logic [31:0] imm_v);
        bus.ImmSrc   = src;
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.rd       = rd_v;
        bus.rs1      = rs1_v;
        bus.rs2      = rs2_v;
        bus.imm      = imm_v;
        bus.in_valid = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.ImmSrc = 2'b00; bus.opcode = '0; bus.funct3 = '0;
        bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;

        #12;
        chk("rst_we", bus.imem_we, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_wdata", bus.imem_wdata, 0);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_count", count, 0);

        // IDLE ignores in_valid
        @(negedge clk);
        rst_n = 1'b1;
        present(2'b00, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("idle_ready", bus.in_ready, 0);
        chk("idle_we", bus.imem_we, 0);
        bus.in_valid = 1'b0;
        start = 1'b1;

        @(negedge clk);
        start = 1'b0;
        chk("run_busy", busy, 1);
        chk("run_count0", count, 0);
        present(2'b00, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        #1 chk("run_ready", bus.in_ready, 1);

        @(negedge clk);
        chk("i_we", bus.imem_we, 1);
        chk("i_addr", bus.imem_addr, 32'h0);
        chk("i_wdata", bus.imem_wdata, 32'hFFF0_0093);
        chk("i_count", count, 1);
        present(2'b01, 7'h23, 3'd2, 5'd0, 5'd3, 5'd2, 32'd8);

        @(negedge clk);
        chk("s_we", bus.imem_we, 1);
        chk("s_addr", bus.imem_addr, 32'h4);
        chk("s_wdata", bus.imem_wdata, 32'h0021_A423);
        chk("s_count", count, 2);
        present(2'b10, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);

        @(negedge clk);
        chk("b_we", bus.imem_we, 1);
        chk("b_addr", bus.imem_addr, 32'h8);
        chk("b_wdata", bus.imem_wdata, 32'hFE20_8EE3);
        chk("b_count", count, 3);
        chk("b_not_full", full, 0);
        present(2'b00, 7'h13, 3'd0, 5'd5, 5'd5, 5'd0, 32'd5);

        // fourth accept fills the session; fifth bundle stays presented
        @(negedge clk);
        chk("f_we", bus.imem_we, 1);
        chk("f_addr", bus.imem_addr, 32'hC);
        chk("f_wdata", bus.imem_wdata, 32'h0052_8293);
        chk("f_full", full, 1);
        chk("f_ready", bus.in_ready, 0);
        chk("f_count", count, 4);

        @(negedge clk);
        chk("f5_we", bus.imem_we, 0);
        chk("f5_count", count, 4);
        chk("f5_full", full, 1);
        bus.in_valid = 1'b0;
        start = 1'b1;

        // start while RUN with a bundle presented: not accepted that cycle
        @(negedge clk);
        present(2'b00, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        #1 chk("st_ready", bus.in_ready, 0);

        @(negedge clk);
        start = 1'b0;
        chk("st_noacc_err", err, 0);
        chk("st_noacc_we", bus.imem_we, 0);
        chk("st_busy", busy, 1);

        @(negedge clk);
        chk("rng_err", err, 1);
        chk("rng_code", err_code, 2'b01);
        chk("rng_we", bus.imem_we, 0);
        chk("rng_ready", bus.in_ready, 0);
        chk("rng_count", count, 0);
        start = 1'b1;
        present(2'b10, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd5);

        @(negedge clk);
        start = 1'b0;
        chk("clr_err", err, 0);
        chk("clr_code", err_code, 0);

        @(negedge clk);
        chk("mis_err", err, 1);
        chk("mis_code", err_code, 2'b10);
        chk("mis_we", bus.imem_we, 0);
        bus.in_valid = 1'b0;
        start = 1'b1;

        @(negedge clk);
        start = 1'b0;
        present(2'b11, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8);

        @(negedge clk);
`ifdef IMM_J_TYPE_EN
        chk("j_we", bus.imem_we, 1);
        chk("j_addr", bus.imem_addr, 32'h0);
        chk("j_wdata", bus.imem_wdata, 32'h0080_00EF);
        chk("j_err", err, 0);
`else
        chk("j_we", bus.imem_we, 0);
        chk("j_err", err, 1);
        chk("j_code", err_code, 2'b11);
`endif
        bus.in_valid = 1'b0;
        start = 1'b1;

        @(negedge clk);
        start = 1'b0;
        present(2'b00, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);

        // asynchronous reset while a write is on the port
        @(negedge clk);
        chk("ar_we_pre", bus.imem_we, 1);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_we", bus.imem_we, 0);
        chk("ar_addr", bus.imem_addr, 0);
        chk("ar_wdata", bus.imem_wdata, 0);
        chk("ar_count", count, 0);
        chk("ar_busy", busy, 0);
        chk("ar_ready", bus.in_ready, 0);

        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;

        @(negedge clk);
        start = 1'b0;
        present(2'b01, 7'h23, 3'd2, 5'd0, 5'd3, 5'd2, 32'd8);

        @(negedge clk);
        chk("rs_we", bus.imem_we, 1);
        chk("rs_addr", bus.imem_addr, 32'h0);
        chk("rs_wdata", bus.imem_wdata, 32'h0021_A423);
        chk("rs_count", count, 1);
        bus.in_valid = 1'b0;

        @(negedge clk);
        chk("rs_we_pulse", bus.imem_we, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
